// File: rtl/line_sensor_scanner_pkg.sv
// line_sensor_pkg: shared sizes and types for the RC line sensor scanner
package line_sensor_pkg;
   localparam int NUM_SENSORS = 8;
   typedef enum logic [2:0] {IDLE, SETTLE, CHARGE, MEASURE, UPDATE, WAIT} scan_state_t;
   typedef logic [NUM_SENSORS-1:0] line_pattern_t;
endpackage

// File: rtl/line_sensor_scanner_sync2.sv
// sync2: two-flop synchronizer for asynchronous multi-bit inputs
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;
   always_ff @(posedge clk)
      if (reset) {q, meta} <= '0;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/line_sensor_scanner.sv
// line_sensor_scanner: times RC sensor discharge each scan and publishes a debounced line pattern
module line_sensor_scanner
   import line_sensor_pkg::*;
#(
   parameter int SETTLE_CYCLES    = 500,
   parameter int CHARGE_CYCLES    = 500,
   parameter int THRESHOLD_CYCLES = 50000,
   parameter int PERIOD_CYCLES    = 250000,
   parameter int DEBOUNCE_SCANS   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] sensor_in,
   output logic                   sensor_drive,
   output logic                   emitter_on,
   output logic [NUM_SENSORS-1:0] line_bits,
   output logic                   line_valid,
   output logic                   scan_done,
   output logic                   busy
);
   localparam int CW = $clog2(PERIOD_CYCLES);
   localparam logic [CW-1:0] SETTLE_END  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CHARGE_END  = CW'(SETTLE_CYCLES + CHARGE_CYCLES - 1);
   localparam logic [CW-1:0] MEASURE_END = CW'(SETTLE_CYCLES + CHARGE_CYCLES + THRESHOLD_CYCLES - 1);
   localparam logic [CW-1:0] PERIOD_END  = CW'(PERIOD_CYCLES - 1);
   localparam logic [3:0]    DB          = 4'(DEBOUNCE_SCANS);
   if (PERIOD_CYCLES < SETTLE_CYCLES + CHARGE_CYCLES + THRESHOLD_CYCLES + 2) begin : g_period_chk
      $error("PERIOD_CYCLES too short for one scan");
   end
   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_debounce_chk
      $error("DEBOUNCE_SCANS must be 1..15");
   end
   scan_state_t   state, state_n;
   logic [CW-1:0] per;
   line_pattern_t sync_in, dark, prev_raw;
   logic [3:0]    match_cnt, match_n;
   sync2 #(.WIDTH(NUM_SENSORS)) u_sync (.clk(clk), .reset(reset), .d(sensor_in), .q(sync_in));
   // One counter times the whole scan: it restarts at SETTLE entry and each phase ends at a fixed offset.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = enable ? SETTLE : IDLE;
         SETTLE:  state_n = (per == SETTLE_END) ? CHARGE : SETTLE;
         CHARGE:  state_n = (per == CHARGE_END) ? MEASURE : CHARGE;
         MEASURE: state_n = (per == MEASURE_END) ? UPDATE : MEASURE;
         UPDATE:  state_n = WAIT;
         WAIT:    state_n = (per != PERIOD_END) ? WAIT : enable ? SETTLE : IDLE;
         default: state_n = IDLE;
      endcase
   end
   assign match_n      = (dark == prev_raw) ? ((match_cnt == DB) ? match_cnt : match_cnt + 4'd1) : 4'd1;
   assign emitter_on   = state inside {SETTLE, CHARGE, MEASURE};
   assign sensor_drive = state == CHARGE;
   assign busy         = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         per        <= '0;
         dark       <= '0;
         prev_raw   <= '0;
         match_cnt  <= '0;
         line_bits  <= '0;
         line_valid <= 1'b0;
         scan_done  <= 1'b0;
      end else begin
         state      <= state_n;
         per        <= ((state_n == SETTLE && state != SETTLE) || state_n == IDLE) ? '0 : per + 1'b1;
         dark       <= (state == CHARGE) ? '1 : (state == MEASURE) ? (dark & sync_in) : dark;
         scan_done  <= state == UPDATE;
         line_valid <= state == UPDATE && match_n == DB;
         if (state == UPDATE) begin
            prev_raw  <= dark;
            match_cnt <= match_n;
            if (match_n == DB) line_bits <= dark;
         end
      end
   end
endmodule

// File: tb/tb_line_sensor_scanner.sv
// tb_line_sensor_scanner: table-driven scans against an RC discharge plant model
module tb_line_sensor_scanner;
   logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
   logic [7:0] sensor_in = 8'h00;
   logic       sensor_drive, emitter_on, line_valid, scan_done, busy;
   logic [7:0] line_bits;
   typedef struct {
      logic [7:0] hi, late, glitch;
      int         late_at;
      logic [7:0] exp_bits;
      logic       exp_valid;
   } vec_t;
   localparam int NV = 19;
   vec_t vecs [NV];
   vec_t cur;
   int checks = 0, failures = 0, cyc = 0, rel = 1000, drv = 0, emi = 0, vcnt = 0, last_done = 0, n = 0;
   always #5 clk = ~clk;
   line_sensor_scanner #(
      .SETTLE_CYCLES(2), .CHARGE_CYCLES(4), .THRESHOLD_CYCLES(20), .PERIOD_CYCLES(40), .DEBOUNCE_SCANS(2)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .sensor_in(sensor_in), .sensor_drive(sensor_drive),
      .emitter_on(emitter_on), .line_bits(line_bits), .line_valid(line_valid), .scan_done(scan_done), .busy(busy)
   );
   function automatic vec_t mk(logic [7:0] hi, logic [7:0] late, int late_at, logic [7:0] glitch, logic [7:0] eb, logic ev);
      vec_t v;
      v.hi = hi; v.late = late; v.late_at = late_at; v.glitch = glitch; v.exp_bits = eb; v.exp_valid = ev;
      return v;
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   // Plant: rel is the MEASURE cycle index (-1 while charging); sync delay is folded in as rel-2.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      rel = sensor_drive ? -1 : rel + 1;
      drv += int'(sensor_drive);
      emi += int'(emitter_on);
      vcnt += int'(line_valid);
      for (int i = 0; i < 8; i++)
         sensor_in[i] = cur.hi[i] ? !(cur.glitch[i] && rel == 6) : cur.late[i] ? (rel < cur.late_at - 2) : 1'b0;
   endtask
   task automatic wait_done(input string name);
      n = 0;
      while (!scan_done && n < 100) begin tick(); n++; end
      chk({name, " scan_done"}, int'(scan_done), 1);
   endtask
   task automatic wait_drive(input logic lvl, input string name);
      n = 0;
      while (sensor_drive !== lvl && n < 100) begin tick(); n++; end
      chk(name, int'(sensor_drive), int'(lvl));
   endtask
   task automatic do_reset();
      reset = 1'b1; enable = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask
   initial begin
      vecs[0]  = mk(8'h18, 8'h00, 0, 8'h00, 8'h00, 1'b0);
      vecs[1]  = mk(8'h0C, 8'h00, 0, 8'h00, 8'h00, 1'b0);
      vecs[2]  = mk(8'h18, 8'h00, 0, 8'h00, 8'h00, 1'b0);
      vecs[3]  = mk(8'h0C, 8'h00, 0, 8'h00, 8'h00, 1'b0);
      vecs[4]  = mk(8'h0C, 8'h00, 0, 8'h00, 8'h0C, 1'b1);
      vecs[5]  = mk(8'h18, 8'h00, 0, 8'h00, 8'h0C, 1'b0);
      vecs[6]  = mk(8'h18, 8'h00, 0, 8'h00, 8'h18, 1'b1);
      vecs[7]  = mk(8'h18, 8'h00, 0, 8'h00, 8'h18, 1'b1);
      vecs[8]  = mk(8'h02, 8'h01, 17, 8'h00, 8'h18, 1'b0);
      vecs[9]  = mk(8'h02, 8'h01, 17, 8'h00, 8'h02, 1'b1);
      vecs[10] = mk(8'h01, 8'hC0, 20, 8'h00, 8'h02, 1'b0);
      vecs[11] = mk(8'h01, 8'hC0, 19, 8'h00, 8'h02, 1'b0);
      vecs[12] = mk(8'h01, 8'hC0, 19, 8'h00, 8'h01, 1'b1);
      vecs[13] = mk(8'h18, 8'h00, 0, 8'h10, 8'h01, 1'b0);
      vecs[14] = mk(8'h18, 8'h00, 0, 8'h10, 8'h08, 1'b1);
      vecs[15] = mk(8'hFF, 8'h00, 0, 8'h00, 8'h08, 1'b0);
      vecs[16] = mk(8'hFF, 8'h00, 0, 8'h00, 8'hFF, 1'b1);
      vecs[17] = mk(8'h00, 8'h00, 0, 8'h00, 8'hFF, 1'b0);
      vecs[18] = mk(8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1);
      cur = vecs[0];
      tick(); tick();
      chk("reset line_bits", int'(line_bits), 0);
      chk("reset line_valid", int'(line_valid), 0);
      chk("reset scan_done", int'(scan_done), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset emitter_on", int'(emitter_on), 0);
      chk("reset sensor_drive", int'(sensor_drive), 0);
      reset = 1'b0;
      repeat (5) tick();
      chk("idle without enable", int'(busy), 0);
      drv = 0; emi = 0;
      enable = 1'b1;
      tick();
      chk("settle after enable", int'({busy, emitter_on, sensor_drive}), 3'b110);
      for (int v = 0; v < NV; v++) begin
         cur = vecs[v];
         if (v > 0) begin drv = 0; emi = 0; end
         wait_done($sformatf("v%0d", v));
         chk($sformatf("v%0d line_valid", v), int'(line_valid), int'(vecs[v].exp_valid));
         chk($sformatf("v%0d line_bits", v), int'(line_bits), int'(vecs[v].exp_bits));
         chk($sformatf("v%0d drive cycles", v), drv, 4);
         chk($sformatf("v%0d emitter cycles", v), emi, 26);
         if (v > 0) chk($sformatf("v%0d scan spacing", v), cyc - last_done, 40);
         last_done = cyc;
         tick();
         chk($sformatf("v%0d pulse width", v), int'({line_valid, scan_done}), 0);
      end
      // Enable dropped during CHARGE of scan 3: scan finishes, then IDLE at period end.
      cur = vecs[7];
      do_reset();
      enable = 1'b1;
      wait_done("e1");
      chk("e1 no early valid", int'(line_valid), 0);
      tick();
      wait_done("e2");
      chk("e2 first valid", int'({line_valid, line_bits}), 9'h118);
      tick();
      wait_drive(1'b1, "e3 charge reached");
      enable = 1'b0;
      wait_done("e3");
      chk("e3 line_valid", int'(line_valid), 1);
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("busy falls at period end", n, 13);
      emi = 0;
      repeat (60) tick();
      chk("stays idle", int'({busy, emitter_on}), 0);
      chk("no emitter while idle", emi, 0);
      chk("line_bits held", int'(line_bits), 8'h18);
      // Reset mid-MEASURE after 8'h18 has been published.
      do_reset();
      enable = 1'b1;
      wait_done("r1");
      tick();
      wait_done("r2");
      chk("r2 line_bits", int'(line_bits), 8'h18);
      tick();
      wait_drive(1'b1, "r3 charge reached");
      wait_drive(1'b0, "r3 measure reached");
      repeat (5) tick();
      chk("r3 in measure", int'({busy, emitter_on, sensor_drive}), 3'b110);
      vcnt = 0;
      reset = 1'b1;
      tick();
      chk("abort line_bits", int'(line_bits), 0);
      chk("abort outputs", int'({line_valid, scan_done, busy, emitter_on, sensor_drive}), 0);
      reset = 1'b0;
      enable = 1'b0;
      repeat (60) tick();
      chk("abort no valid pulse", vcnt, 0);
      chk("abort stays idle", int'({busy, line_bits}), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
